dm_port_arbiter: RTL and testbench

//  Sequences all data-memory accesses and shares the single DM port between two requesters:
//  A = CPU MEM stage, B = secondary master (DMA/debug). Arbitrates, derives byte enables,

---
 rtl/dm_port_arbiter.sv | 192 +++++++++++++++++++
 tb/tb_dm_port_arbiter.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/dm_port_arbiter.sv
// Data-memory port arbiter: shares one fixed-latency synchronous DM port between the
// CPU MEM stage (A) and a secondary master (B), steering byte lanes in both directions.
module dm_port_arbiter #(
  parameter int unsigned MEM_LAT = 1,
  parameter bit          RR      = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        a_req,
  input  logic        a_we,
  input  logic [1:0]  a_size,
  input  logic [31:0] a_addr,
  input  logic [31:0] a_wdata,
  output logic        a_ack,
  output logic        a_err,
  output logic [31:0] a_rdata,
  input  logic        b_req,
  input  logic        b_we,
  input  logic [1:0]  b_size,
  input  logic [31:0] b_addr,
  input  logic [31:0] b_wdata,
  output logic        b_ack,
  output logic        b_err,
  output logic [31:0] b_rdata,
  output logic        m_en,
  output logic        m_we,
  output logic [31:0] m_addr,
  output logic [3:0]  m_byteen,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata,
  output logic        owner
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_e;

  localparam logic [3:0] CNT_INIT = 4'(MEM_LAT - 32'd1);

  function automatic logic bad_access(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'd0:    return 1'b0;
      2'd1:    return off[0];
      2'd2:    return (off != 2'd0);
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'd0:    return 4'b0001 << off;
      2'd1:    return off[1] ? 4'b1100 : 4'b0011;
      2'd2:    return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic [31:0] replicate(input logic [1:0] size, input logic [31:0] wd);
    case (size)
      2'd0:    return {4{wd[7:0]}};
      2'd1:    return {2{wd[15:0]}};
      2'd2:    return wd;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] extract(input logic [1:0] size, input logic [1:0] off,
                                          input logic [31:0] word);
    case (size)
      2'd0:    return {24'd0, word[{off, 3'b000} +: 8]};
      2'd1:    return off[1] ? {16'd0, word[31:16]} : {16'd0, word[15:0]};
      2'd2:    return word;
      default: return 32'd0;
    endcase
  endfunction

  state_e      state_q, state_d;
  logic        last_grant_q, last_grant_d;
  logic        owner_q, owner_d;
  logic        we_q, we_d;
  logic [1:0]  size_q, size_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        err_q, err_d;
  logic [3:0]  cnt_q, cnt_d;

  logic        grant_b_s;
  logic [1:0]  req_size_s;
  logic [31:0] req_addr_s;
  logic        req_bad_s;

  // On a tie with round-robin enabled, B wins only if A was granted last.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    we_d         = we_q;
    size_d       = size_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    err_d        = err_q;
    cnt_d        = cnt_q;
    grant_b_s    = b_req & (~a_req | (RR & ~last_grant_q));
    req_size_s   = grant_b_s ? b_size : a_size;
    req_addr_s   = grant_b_s ? b_addr : a_addr;
    req_bad_s    = bad_access(req_size_s, req_addr_s[1:0]);
    case (state_q)
      S_IDLE: begin
        if (a_req | b_req) begin
          last_grant_d = grant_b_s;
          owner_d      = grant_b_s;
          we_d         = grant_b_s ? b_we : a_we;
          size_d       = req_size_s;
          addr_d       = req_addr_s;
          wdata_d      = grant_b_s ? b_wdata : a_wdata;
          err_d        = req_bad_s;
          state_d      = req_bad_s ? S_RESP : S_ISSUE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        if (MEM_LAT == 32'd1) begin
          state_d = S_RESP;
        end else begin
          state_d = S_WAIT;
          cnt_d   = CNT_INIT;
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd1) begin
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and latched-request registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      we_q         <= 1'b0;
      size_q       <= 2'd0;
      addr_q       <= 32'd0;
      wdata_q      <= 32'd0;
      err_q        <= 1'b0;
      cnt_q        <= 4'd0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      we_q         <= we_d;
      size_q       <= size_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      err_q        <= err_d;
      cnt_q        <= cnt_d;
    end
  end

  logic        issue_s, resp_s, load_ok_s;
  logic [31:0] rd_s;

  assign issue_s   = (state_q == S_ISSUE);
  assign resp_s    = (state_q == S_RESP);
  assign load_ok_s = resp_s & ~err_q & ~we_q;
  assign rd_s      = extract(size_q, addr_q[1:0], m_rdata);

  assign m_en     = issue_s;
  assign m_we     = issue_s & we_q;
  assign m_addr   = issue_s ? {addr_q[31:2], 2'b00} : 32'd0;
  assign m_byteen = issue_s ? lane_mask(size_q, addr_q[1:0]) : 4'd0;
  assign m_wdata  = issue_s ? replicate(size_q, wdata_q) : 32'd0;

  assign a_ack   = resp_s & ~owner_q;
  assign a_err   = a_ack & err_q;
  assign a_rdata = (a_ack & load_ok_s) ? rd_s : 32'd0;
  assign b_ack   = resp_s & owner_q;
  assign b_err   = b_ack & err_q;
  assign b_rdata = (b_ack & load_ok_s) ? rd_s : 32'd0;
  assign owner   = owner_q;

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Randomized bench: three arbiters (latency 1/3/15, RR on/off) against a transaction-level
// model built from access timing and lane arithmetic.
module tb_dm_port_arbiter;
  localparam int N = 3;
  localparam int NCYC = 6000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        rq_req  [N][2];
  logic        rq_we   [N][2];
  logic [1:0]  rq_size [N][2];
  logic [31:0] rq_addr [N][2];
  logic [31:0] rq_wd   [N][2];
  logic [31:0] m_rdata [N];

  logic        ack_o  [N][2];
  logic        err_o  [N][2];
  logic [31:0] rd_o   [N][2];
  logic        m_en   [N];
  logic        m_we   [N];
  logic [31:0] m_addr [N];
  logic [3:0]  m_be   [N];
  logic [31:0] m_wd   [N];
  logic        owner_o[N];

  for (genvar g = 0; g < N; g++) begin : g_dut
    dm_port_arbiter #(
      .MEM_LAT(g == 0 ? 1 : (g == 1 ? 3 : 15)),
      .RR     (g == 1 ? 1'b0 : 1'b1)
    ) u_dut (
      .clk(clk), .reset(reset),
      .a_req(rq_req[g][0]), .a_we(rq_we[g][0]), .a_size(rq_size[g][0]),
      .a_addr(rq_addr[g][0]), .a_wdata(rq_wd[g][0]),
      .a_ack(ack_o[g][0]), .a_err(err_o[g][0]), .a_rdata(rd_o[g][0]),
      .b_req(rq_req[g][1]), .b_we(rq_we[g][1]), .b_size(rq_size[g][1]),
      .b_addr(rq_addr[g][1]), .b_wdata(rq_wd[g][1]),
      .b_ack(ack_o[g][1]), .b_err(err_o[g][1]), .b_rdata(rd_o[g][1]),
      .m_en(m_en[g]), .m_we(m_we[g]), .m_addr(m_addr[g]), .m_byteen(m_be[g]),
      .m_wdata(m_wd[g]), .m_rdata(m_rdata[g]), .owner(owner_o[g])
    );
  end

  function automatic int lat_of(input int g);
    return (g == 0) ? 1 : ((g == 1) ? 3 : 15);
  endfunction

  function automatic bit rr_of(input int g);
    return (g != 1);
  endfunction

  // Reference arithmetic: alignment is "address is a multiple of the access width".
  function automatic bit is_bad(input logic [1:0] sz, input logic [31:0] ad);
    return (sz == 2'd3) || ((ad % (32'd1 << sz)) != 32'd0);
  endfunction

  function automatic logic [3:0] exp_be(input logic [1:0] sz, input logic [31:0] ad);
    if (sz == 2'd2) return 4'hF;
    if (sz == 2'd1) return 4'h3 << (ad % 32'd4);
    return 4'h1 << (ad % 32'd4);
  endfunction

  function automatic logic [31:0] exp_wd(input logic [1:0] sz, input logic [31:0] wd);
    if (sz == 2'd0) return (wd % 32'd256) * 32'h01010101;
    if (sz == 2'd1) return (wd % 32'd65536) * 32'h00010001;
    return wd;
  endfunction

  function automatic logic [31:0] exp_rd(input logic [1:0] sz, input logic [31:0] ad,
                                         input logic [31:0] rd);
    longint unsigned w;
    longint unsigned mask;
    w    = longint'(rd) >> (8 * (ad % 32'd4));
    mask = (64'd1 << (8 * (1 << sz))) - 64'd1;
    return 32'(w & mask);
  endfunction

  int n_chk = 0;
  int n_err = 0;
  int ecnt  = -1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s @edge %0d: got %h expected %h", tag, ecnt, obs, exp);
    end
  endtask

  // Model state: one in-flight transaction per arbiter, timed by edge index.
  bit          mb_busy[N];
  int          ms[N];
  int          mr[N];
  bit          mown[N];
  bit          mlast[N];
  bit          mwe[N];
  bit          merr[N];
  logic [1:0]  msize[N];
  logic [31:0] maddr[N];
  logic [31:0] mwd[N];
  bit          got_ack[N][2];

  task automatic model_edge(input int g);
    bit p;
    if (!reset) begin
      mb_busy[g] = 1'b0;
      mlast[g]   = 1'b1;
    end else if (mb_busy[g]) begin
      if (ecnt == mr[g] + 1) mb_busy[g] = 1'b0;
    end else if (rq_req[g][0] || rq_req[g][1]) begin
      if (rq_req[g][0] && rq_req[g][1]) p = rr_of(g) ? !mlast[g] : 1'b0;
      else p = rq_req[g][1];
      mlast[g] = p;
      mown[g]  = p;
      mwe[g]   = rq_we[g][p];
      msize[g] = rq_size[g][p];
      maddr[g] = rq_addr[g][p];
      mwd[g]   = rq_wd[g][p];
      merr[g]  = is_bad(msize[g], maddr[g]);
      ms[g]    = ecnt;
      mr[g]    = merr[g] ? ecnt : ecnt + lat_of(g);
      mb_busy[g] = 1'b1;
    end
  endtask

  task automatic new_req(input int g, input int p);
    int r;
    logic [31:0] ad;
    r = $urandom_range(0, 9);
    rq_req[g][p]  = 1'b1;
    rq_we[g][p]   = 1'($urandom_range(0, 1));
    rq_size[g][p] = (r < 3) ? 2'd0 : ((r < 6) ? 2'd1 : ((r < 9) ? 2'd2 : 2'd3));
    ad = $urandom;
    if ($urandom_range(0, 2) != 0 && rq_size[g][p] != 2'd3)
      ad = ad & ~((32'd1 << rq_size[g][p]) - 32'd1);
    rq_addr[g][p] = ad;
    rq_wd[g][p]   = $urandom;
  endtask

  task automatic drive_req(input int g, input int p);
    if (got_ack[g][p]) begin
      got_ack[g][p] = 1'b0;
      if ($urandom_range(0, 3) != 0) new_req(g, p);
      else rq_req[g][p] = 1'b0;
    end else if (!rq_req[g][p]) begin
      if ($urandom_range(0, 2) == 0) new_req(g, p);
    end else if (mb_busy[g] && (mown[g] == p[0]) && ($urandom_range(0, 3) == 0)) begin
      new_req(g, p);
      rq_req[g][p] = ($urandom_range(0, 7) != 0);
    end
  endtask

  task automatic compare(input int g);
    bit issue, resp;
    logic [9:0] ctl_exp, ctl_obs;
    logic [31:0] rexp;
    issue = mb_busy[g] && !merr[g] && (ecnt == ms[g]);
    resp  = mb_busy[g] && (ecnt == mr[g]);
    ctl_exp = {issue, issue && mwe[g], issue ? exp_be(msize[g], maddr[g]) : 4'h0,
               resp && !mown[g], resp && !mown[g] && merr[g],
               resp && mown[g], resp && mown[g] && merr[g]};
    ctl_obs = {m_en[g], m_we[g], m_be[g], ack_o[g][0], err_o[g][0], ack_o[g][1], err_o[g][1]};
    chk($sformatf("ctl%0d", g), 32'(ctl_obs), 32'(ctl_exp));
    chk($sformatf("m_addr%0d", g), m_addr[g], issue ? (maddr[g] & ~32'd3) : 32'd0);
    chk($sformatf("m_wdata%0d", g), m_wd[g], issue ? exp_wd(msize[g], mwd[g]) : 32'd0);
    for (int p = 0; p < 2; p++) begin
      rexp = (resp && (mown[g] == p[0]) && !merr[g] && !mwe[g])
             ? exp_rd(msize[g], maddr[g], m_rdata[g]) : 32'd0;
      chk($sformatf("rdata%0d_%0d", g, p), rd_o[g][p], rexp);
      if (resp && (mown[g] == p[0])) got_ack[g][p] = 1'b1;
    end
    if (mb_busy[g]) chk($sformatf("owner%0d", g), 32'(owner_o[g]), 32'(mown[g]));
  endtask

  initial begin
    reset = 1'b0;
    for (int g = 0; g < N; g++) begin
      m_rdata[g] = 32'd0;
      for (int p = 0; p < 2; p++) begin
        rq_req[g][p] = 1'b0; rq_we[g][p] = 1'b0; rq_size[g][p] = 2'd0;
        rq_addr[g][p] = 32'd0; rq_wd[g][p] = 32'd0; got_ack[g][p] = 1'b0;
      end
    end
    for (int c = 0; c < NCYC; c++) begin
      @(posedge clk);
      ecnt++;
      for (int g = 0; g < N; g++) model_edge(g);
      #1;
      // Occasional one-cycle reset pulses abort whatever is in flight.
      reset = !((c < 2) || ($urandom_range(0, 199) == 0));
      for (int g = 0; g < N; g++) begin
        m_rdata[g] = $urandom;
        drive_req(g, 0);
        drive_req(g, 1);
      end
      @(negedge clk);
      for (int g = 0; g < N; g++) compare(g);
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
